// File: rtl/sram_loader.sv
// Buffers ioctl download bytes in a small FIFO and replays them as timed async SRAM
// write cycles; when idle the SRAM serves video reads with a registered return.
module sram_loader #(
   parameter int FIFO_DEPTH = 4,
   parameter int WE_CYCLES  = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [15:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic [1:0]  page,
   input  logic [12:0] va,
   output logic [7:0]  vd,
   output logic [20:0] sram_a,
   output logic        sram_we,
   output logic        sram_oe,
   output logic [7:0]  sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [7:0]  sram_dq_in,
   output logic        busy,
   output logic        overflow,
   output logic [1:0]  dbgState
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   logic [15:0]   addrMem [FIFO_DEPTH];
   logic [7:0]    dataMem [FIFO_DEPTH];
   logic [AW-1:0] rdPtr;
   logic [AW-1:0] wrPtr;
   logic [AW:0]   count;

   logic [1:0]    state;
   logic [CW-1:0] weCnt;
   logic [15:0]   wrAddr;
   logic [7:0]    wrData;
   logic          downloadPrev;

   logic fifoEmpty;
   logic fifoFull;
   logic push;
   logic pop;
   logic pushOk;
   logic active;

   assign fifoEmpty = (count == '0);
   assign fifoFull  = (count == (AW+1)'(FIFO_DEPTH));
   assign push      = ioctl_wr & ioctl_download;
   assign pop       = (state == IDLE) & ~fifoEmpty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign pushOk    = push & (~fifoFull | pop);
   assign active    = (state != IDLE);

   always_ff @(posedge clock) begin
      if (pushOk) begin
         addrMem[wrPtr] <= ioctl_addr;
         dataMem[wrPtr] <= ioctl_dout;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (pushOk) wrPtr <= wrPtr + AW'(1);
         if (pop)    rdPtr <= rdPtr + AW'(1);
         case ({pushOk, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         overflow     <= 1'b0;
         downloadPrev <= 1'b0;
      end else begin
         downloadPrev <= ioctl_download;
         if (ioctl_download & ~downloadPrev) overflow <= 1'b0;
         else if (push & ~pushOk)            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         weCnt  <= '0;
         wrAddr <= '0;
         wrData <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  wrAddr <= addrMem[rdPtr];
                  wrData <= dataMem[rdPtr];
                  state  <= SETUP;
               end
            end
            SETUP: begin
               weCnt <= '0;
               state <= WRITE;
            end
            WRITE: begin
               if (weCnt == CW'(WE_CYCLES - 1)) state <= HOLD;
               else                             weCnt <= weCnt + CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Video sees blank data whenever the loader owns the SRAM.
   always_ff @(posedge clock) begin
      if (reset)     vd <= '0;
      else if (busy) vd <= '0;
      else           vd <= sram_dq_in;
   end

   assign busy        = ioctl_download | ~fifoEmpty | active;
   assign sram_we     = (state != WRITE);
   assign sram_oe     = active;
   assign sram_dq_oe  = active;
   assign sram_dq_out = wrData;
   assign sram_a      = busy ? {5'd0, wrAddr} : {6'd0, page, va};
   assign dbgState    = state;

endmodule

// File: tb/tb_sram_loader.sv
// Directed bench for sram_loader: write-cycle timing, FIFO overflow, video read path,
// drain after download end and reset mid-write.
module tb_sram_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [15:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic [1:0]  page = '0;
   logic [12:0] va = '0;
   logic [7:0]  vd;
   logic [20:0] sram_a;
   logic        sram_we;
   logic        sram_oe;
   logic [7:0]  sram_dq_out;
   logic        sram_dq_oe;
   logic [7:0]  sram_dq_in = '0;
   logic        busy;
   logic        overflow;
   logic [1:0]  dbgState;

   int nChecks = 0;
   int nFails  = 0;

   logic [28:0] expQ[$];
   logic [28:0] gotQ[$];

   int          lowRun = 0;
   logic        sawReset = 1'b0;
   logic [20:0] capA;
   logic [7:0]  capD;

   sram_loader #(.FIFO_DEPTH(4), .WE_CYCLES(2)) dut (
      .clock(clock), .reset(reset), .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .page(page), .va(va), .vd(vd), .sram_a(sram_a), .sram_we(sram_we),
      .sram_oe(sram_oe), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .busy(busy), .overflow(overflow), .dbgState(dbgState)
   );

   always #5 clock = ~clock;

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Records each write at its first low-WE cycle; checks pulse width and hold stability.
   always @(negedge clock) begin
      if (reset) sawReset = 1'b1;
      if (!sram_we) begin
         if (lowRun == 0) begin
            capA = sram_a;
            capD = sram_dq_out;
            gotQ.push_back({sram_a, sram_dq_out});
         end else if (!sawReset) begin
            checkEq("we_addr_stable", {11'd0, sram_a}, {11'd0, capA});
            checkEq("we_data_stable", {24'd0, sram_dq_out}, {24'd0, capD});
         end
         lowRun++;
      end else begin
         if (lowRun != 0 && !sawReset) begin
            checkEq("we_width", lowRun, 2);
            checkEq("hold_addr", {11'd0, sram_a}, {11'd0, capA});
            checkEq("hold_data", {24'd0, sram_dq_out}, {24'd0, capD});
            checkEq("hold_dq_oe", {31'd0, sram_dq_oe}, 1);
         end
         lowRun   = 0;
         sawReset = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic strobe(input logic [15:0] a, input logic [7:0] d);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      tick(1);
      ioctl_wr = 1'b0;
   endtask

   task automatic waitWrites();
      int i;
      for (i = 0; i < 300; i++) begin
         if (gotQ.size() >= expQ.size()) break;
         tick(1);
      end
      if (i == 300) checkEq("write_timeout", 0, 1);
      tick(4);
   endtask

   task automatic compareQueues(input string tag);
      checkEq({tag, "_count"}, gotQ.size(), expQ.size());
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
         checkEq({tag, "_entry"}, {3'd0, gotQ[i]}, {3'd0, expQ[i]});
      gotQ.delete();
      expQ.delete();
   endtask

   initial begin
      // Reset state
      tick(2);
      checkEq("rst_we", sram_we, 1);
      checkEq("rst_oe", sram_oe, 0);
      checkEq("rst_dq_oe", sram_dq_oe, 0);
      checkEq("rst_vd", vd, 0);
      checkEq("rst_ovf", overflow, 0);
      checkEq("rst_sram_a", sram_a, 0);
      checkEq("rst_state", dbgState, 0);
      checkEq("rst_busy", busy, 0);
      reset = 1'b0;
      tick(1);

      // Single write: SETUP one cycle after the pop, WE low on cycles 2 and 3 after the strobe
      ioctl_download = 1'b1;
      tick(1);
      strobe(16'h1234, 8'hA5);
      expQ.push_back({21'h01234, 8'hA5});
      tick(1);
      checkEq("setup_we", sram_we, 1);
      checkEq("setup_a", sram_a, 21'h01234);
      checkEq("setup_dq", sram_dq_out, 8'hA5);
      checkEq("setup_dq_oe", sram_dq_oe, 1);
      checkEq("setup_oe", sram_oe, 1);
      tick(1);
      checkEq("write1_we", sram_we, 0);
      tick(1);
      checkEq("write2_we", sram_we, 0);
      tick(1);
      checkEq("hold_we", sram_we, 1);
      checkEq("hold_dq_oe_c", sram_dq_oe, 1);
      tick(1);
      checkEq("idle_dq_oe", sram_dq_oe, 0);
      checkEq("idle_busy", busy, 1);
      ioctl_download = 1'b0;
      tick(1);
      checkEq("busy_after_dl", busy, 0);
      compareQueues("single");

      // Burst of six back-to-back strobes into a depth-4 FIFO: sixth byte dropped
      ioctl_download = 1'b1;
      tick(1);
      for (int i = 0; i < 6; i++) begin
         if (i < 5) expQ.push_back({21'(i), 8'(8'h10 + i)});
         strobe(16'(i), 8'(8'h10 + i));
      end
      checkEq("burst_ovf", overflow, 1);
      checkEq("burst_vd_blank", vd, 0);
      waitWrites();
      compareQueues("burst");
      checkEq("ovf_sticky", overflow, 1);
      ioctl_download = 1'b0;
      tick(1);
      checkEq("ovf_held_low_dl", overflow, 1);
      ioctl_download = 1'b1;
      tick(1);
      checkEq("ovf_cleared", overflow, 0);

      // Paced burst: one strobe every five cycles never overflows
      for (int i = 0; i < 20; i++) begin
         expQ.push_back({21'(16'h8000 + i * 3), 8'(i * 7 + 3)});
         strobe(16'(16'h8000 + i * 3), 8'(i * 7 + 3));
         tick(4);
      end
      waitWrites();
      checkEq("paced_ovf", overflow, 0);
      compareQueues("paced");

      // Read path: combinational address, one-cycle registered data
      ioctl_download = 1'b0;
      tick(2);
      page       = 2'd2;
      va         = 13'h0ABC;
      sram_dq_in = 8'h5A;
      #1;
      checkEq("rd_a", sram_a, 21'h004ABC);
      checkEq("rd_vd_before", vd, 0);
      checkEq("rd_oe", sram_oe, 0);
      checkEq("rd_dq_oe", sram_dq_oe, 0);
      tick(1);
      checkEq("rd_vd", vd, 8'h5A);
      page       = 2'd1;
      va         = 13'h1FFF;
      sram_dq_in = 8'hC3;
      #1;
      checkEq("rd2_a", sram_a, 21'h003FFF);
      checkEq("rd2_vd_old", vd, 8'h5A);
      tick(1);
      checkEq("rd2_vd", vd, 8'hC3);

      // Drain after download ends with entries still pending
      ioctl_download = 1'b1;
      tick(1);
      for (int i = 0; i < 3; i++) begin
         expQ.push_back({21'(16'h0100 + i), 8'(8'hE0 + i)});
         strobe(16'(16'h0100 + i), 8'(8'hE0 + i));
      end
      ioctl_download = 1'b0;
      begin
         int n;
         for (n = 0; n < 40; n++) begin
            tick(1);
            if (!busy) break;
            checkEq("drain_vd_blank", vd, 0);
         end
         if (n == 40) checkEq("drain_timeout", 0, 1);
         checkEq("drain_writes_at_idle", gotQ.size(), 3);
         checkEq("drain_state_idle", dbgState, 0);
      end
      compareQueues("drain");
      sram_dq_in = 8'h77;
      tick(1);
      checkEq("drain_read_resume", vd, 8'h77);

      // Reset during WRITE with two entries queued
      ioctl_download = 1'b1;
      tick(1);
      strobe(16'h0200, 8'h11);
      strobe(16'h0201, 8'h22);
      strobe(16'h0202, 8'h33);
      expQ.push_back({21'h00200, 8'h11});
      checkEq("pre_rst_state", dbgState, 2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      checkEq("midrst_we", sram_we, 1);
      checkEq("midrst_busy", busy, 1);
      checkEq("midrst_state", dbgState, 0);
      checkEq("midrst_dq_oe", sram_dq_oe, 0);
      tick(20);
      checkEq("midrst_no_writes", gotQ.size(), 1);
      compareQueues("midrst");
      ioctl_download = 1'b0;
      tick(1);
      checkEq("midrst_busy_end", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
